prod_denorm_writer: RTL
=======================

Name: prod_denorm_writer

Overview:
Downstream stage of the approximate-multiplier datapath. It accepts the 16-bit truncated product of two normalized operands and their leading-zero shift counts. It denormalizes the product into a 32-bit result with a serial shift, one bit per cycle. It then writes the result into the 8-entry output RAM at a self-managed address and signals frame completion after 8 writes.

Parameters:
PROD_W, 16, width of truncated product input (8x8 multiply of operand top bytes)
RES_W, 32, width of denormalized result / output RAM data
CNT_W, 4, width of each operand shift count (0..15)
ADDR_W, 3, output RAM address width; frame length = 2**ADDR_W results

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: capture prod/sh_cnt1/sh_cnt2/zero_op
prod  input  PROD_W  truncated product of normalized operand top bytes
sh_cnt1  input  CNT_W  left-shift count applied to operand 1
sh_cnt2  input  CNT_W  left-shift count applied to operand 2
zero_op  input  1  either operand was zero; result forced to 0
busy  output  1  high from capture until write cycle completes
done  output  1  one-cycle pulse after each RAM write
frame_done  output  1  sticky; set after write to address 2**ADDR_W-1
frame_clr  input  1  clears frame_done and resets write address to 0
ram_wr  output  1  output RAM write enable (one cycle per result)
ram_addr  output  ADDR_W  output RAM write address
ram_data  output  RES_W  output RAM write data (result register)

Behaviour:
- Reset values: all outputs 0; state IDLE; write address 0; result register 0; frame_done 0.
- Clock is clk; reset is synchronous, active-high, named rst. Reset mid-operation aborts the current result without writing; the address returns to 0.
- total = sh_cnt1 + sh_cnt2, computed at CNT_W+1 bits (0..30). If total <= 16: dir = left, amount = 16 - total. Otherwise dir = right, amount = total - 16.
- States:
  - IDLE: on start, load result reg = {16'b0, prod} (or 0 if zero_op), load the shift counter with amount, latch dir, go to SHIFT. busy=1 from the next cycle.
  - SHIFT: while counter != 0, shift the reg 1 bit in dir, zero-fill, and decrement the counter. When the counter is 0 (including amount 0 on entry), go to WRITE.
  - WRITE: ram_wr=1 for exactly one cycle, with ram_addr = current address and ram_data = reg. Increment the address, wrapping 7->0. If the address was 7, set frame_done. Go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- Latency: write occurs amount+2 cycles after the start cycle; done follows 1 cycle later. Worst case amount=16.
- start while busy is ignored, and inputs are not re-captured.
- frame_clr takes priority over the frame_done set in the same cycle. If frame_clr coincides with a WRITE, the write uses the old address and the address then becomes 0.
- Bits shifted out in the right direction are discarded (truncation, no rounding). Bits shifted out in the left direction cannot be lost, since the max shift is 16 of a 16-bit value.
- ram_data is valid only while ram_wr=1. It otherwise reflects the internal register.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SHIFT, WRITE, DONE)
  - constant NORM_BIAS = 16
  - FRAME_LEN = 8
  - PROD_W/RES_W/CNT_W/ADDR_W defaults shared with the datapath
- One sub-module, bidir_shift_reg: RES_W-bit register with load, shift_en, and dir; zero-filling.
- The FSM, shift-amount computation, and address counter live in the top.

Test Plan:
- prod=0x4000, sh_cnt1=8, sh_cnt2=8 (total 16) -> no shift; ram_wr at start+2, ram_addr=0, ram_data=0x00004000; done at start+3.
- prod=0x4000, sh_cnt1=0, sh_cnt2=0 -> left 16; ram_data=0x40000000 at start+18; busy high for exactly 18 cycles.
- prod=0xE100, sh_cnt1=12, sh_cnt2=12 (total 24) -> right 8; ram_data=0x000000E1 (15*15=225).
- zero_op=1 with prod=0xFFFF, counts 3/4 -> ram_data=0x00000000 and the normal write/done sequence occurs.
- Eight back-to-back results -> addresses 0..7 in order and frame_done rises after the 8th write. A ninth result writes address 0. frame_clr then drops frame_done.
- Assert rst during SHIFT, and separately pulse start while busy -> reset case: no ram_wr, address=0, outputs 0. Busy case: the second start is ignored and the original result is written unchanged.

Source files
------------

// File: rtl/prod_denorm_writer_pkg.sv
// -----------------------------------------------------------------------------
// prod_denorm_writer_pkg
// Shared definitions for the product denormalizer / output RAM writer:
//   - default datapath widths shared with the upstream multiplier stages
//   - NORM_BIAS: shift count at which the truncated product needs no shift
//   - FRAME_LEN: number of results per output RAM frame
//   - FSM state encoding and shift direction type
// -----------------------------------------------------------------------------
package prod_denorm_writer_pkg;

   localparam int FRAME_LEN  = 8;
   localparam int NORM_BIAS  = 16;

   localparam int PROD_W_DEF = 16;
   localparam int RES_W_DEF  = 32;
   localparam int CNT_W_DEF  = 4;
   localparam int ADDR_W_DEF = $clog2(FRAME_LEN);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } shift_dir_t;

endpackage

// File: rtl/prod_denorm_writer_bidir_shift_reg.sv
// -----------------------------------------------------------------------------
// bidir_shift_reg
// W-bit register with parallel load and a one-bit-per-cycle shift in either
// direction. Vacated bit positions are zero-filled; bits shifted out are lost.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (register -> 0)
//   load      : load load_val (has priority over shift_en)
//   load_val  : parallel load value
//   shift_en  : shift one position in direction dir
//   dir       : DIR_LEFT (towards MSB) or DIR_RIGHT (towards LSB)
//   q         : register contents
// -----------------------------------------------------------------------------
module bidir_shift_reg
   import prod_denorm_writer_pkg::*;
#(
   parameter int W = RES_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift_en,
   input  shift_dir_t   dir,
   output logic [W-1:0] q
);

   // NOTE: registers are assigned with <= so every flop samples the values
   // present before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift_en) begin
         if (dir == DIR_LEFT) q <= {q[W-2:0], 1'b0};
         else                 q <= {1'b0, q[W-1:1]};
      end
   end

endmodule

// File: rtl/prod_denorm_writer.sv
// -----------------------------------------------------------------------------
// prod_denorm_writer
// Takes the truncated product of two normalized operands plus their leading-
// zero shift counts, denormalizes it by a serial shift (one bit per cycle)
// into a RES_W-bit result and writes it into the output RAM at a self-managed
// address. frame_done is set once the last address of the frame is written.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle pulse, captures prod/sh_cnt1/sh_cnt2/zero_op
//   prod                : truncated product of operand top bytes
//   sh_cnt1, sh_cnt2    : left-shift counts applied to the operands
//   zero_op             : an operand was zero, result forced to 0
//   busy                : result in flight (capture until write completes)
//   done                : one-cycle pulse after each RAM write
//   frame_done          : sticky, set after the write to the last address
//   frame_clr           : clears frame_done and returns write address to 0
//   ram_wr/addr/data    : output RAM write port (data valid while ram_wr)
// -----------------------------------------------------------------------------
module prod_denorm_writer
   import prod_denorm_writer_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int RES_W  = RES_W_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PROD_W-1:0] prod,
   input  logic [CNT_W-1:0]  sh_cnt1,
   input  logic [CNT_W-1:0]  sh_cnt2,
   input  logic              zero_op,
   output logic              busy,
   output logic              done,
   output logic              frame_done,
   input  logic              frame_clr,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [RES_W-1:0]  ram_data
);

   // One extra bit so the sum of two counts (up to 30) and the bias fit.
   localparam int                AMT_W     = CNT_W + 1;
   localparam logic [AMT_W-1:0]  BIAS      = AMT_W'(NORM_BIAS);
   localparam logic [AMT_W-1:0]  AMT_ONE   = AMT_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state, state_nxt;
   logic [AMT_W-1:0]  total, amount, cnt;
   shift_dir_t        dir_in, dir;
   logic [ADDR_W-1:0] addr;
   logic              load, shift_en;
   logic [RES_W-1:0]  load_val, res;

   // The product is aligned as if both operands had exactly NORM_BIAS bits of
   // normalization; the difference from that decides direction and distance.
   assign total = AMT_W'(sh_cnt1) + AMT_W'(sh_cnt2);

   always_comb begin
      if (total <= BIAS) begin
         dir_in = DIR_LEFT;
         amount = BIAS - total;
      end else begin
         dir_in = DIR_RIGHT;
         amount = total - BIAS;
      end
   end

   assign load_val = zero_op ? '0 : RES_W'(prod);
   assign load     = (state == ST_IDLE) && start;
   assign shift_en = (state == ST_SHIFT) && (cnt != '0);

   bidir_shift_reg #(.W(RES_W)) u_shift (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .shift_en (shift_en),
      .dir      (dir),
      .q        (res)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      ram_wr    = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SHIFT;
         ST_SHIFT: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            busy      = 1'b1;
            ram_wr    = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Shift counter and latched direction; inputs are only captured in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         dir <= DIR_LEFT;
      end else if (load) begin
         cnt <= amount;
         dir <= dir_in;
      end else if (shift_en) begin
         cnt <= cnt - AMT_ONE;
      end
   end

   // Write address and frame flag. frame_clr is applied last so it wins over
   // a same-cycle increment/set; the write itself still used the old address.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr       <= '0;
         frame_done <= 1'b0;
      end else begin
         if (ram_wr) begin
            addr <= addr + ADDR_ONE;
            if (addr == LAST_ADDR) frame_done <= 1'b1;
         end
         if (frame_clr) begin
            addr       <= '0;
            frame_done <= 1'b0;
         end
      end
   end

   assign ram_addr = addr;
   assign ram_data = res;

endmodule
